cdb_arbiter: RTL and testbench

- Round-robin arbiter sharing the single Common Data Bus (CDB) among four functional-unit result ports: 0=ALU, 1=MUL, 2=DIV, 3=LD/ST.
- Grants at most one requester per cycle and drives the 2-bit select of a 4:1 data mux.
- Registers the winning result onto the CDB for the reservation stations and the register file/ROB.
- Supports downstream backpressure and a pipeline flush.

---
 rtl/cdb_pkg.sv | 34 +++
 rtl/mux4_1.sv | 24 ++
 rtl/rr_pick4.sv | 33 +++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the Common Data Bus arbiter: unit indices,
// default widths, the registered CDB word and a one-hot encode helper.
package cdb_pkg;

    localparam int NUM_FU     = 4;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 6;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_DIV = 2'd2;
    localparam logic [1:0] FU_LSU = 2'd3;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic [1:0]            src;
    } cdb_word_t;

    // A zero vector encodes to 0; callers qualify the index with the grant itself.
    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// Generic 4:1 multiplexer used for the CDB data and tag paths.
module mux4_1 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Select one of four inputs.
    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or after ptr,
// wrapping modulo 4, returned both one-hot and encoded.
module rr_pick4
    import cdb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] cand_s;
    logic       found_s;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt     = 4'b0000;
        found_s = 1'b0;
        cand_s  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand_s = ptr + k[1:0];
            if (!found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idx = onehot4_to_idx(gnt);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single Common Data Bus: picks one functional-unit
// result per cycle and registers it onto the bus, honouring backpressure and flush.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_valid_i,
    input  logic [DATA_W-1:0] req_data0_i,
    input  logic [DATA_W-1:0] req_data1_i,
    input  logic [DATA_W-1:0] req_data2_i,
    input  logic [DATA_W-1:0] req_data3_i,
    input  logic [TAG_W-1:0]  req_tag0_i,
    input  logic [TAG_W-1:0]  req_tag1_i,
    input  logic [TAG_W-1:0]  req_tag2_i,
    input  logic [TAG_W-1:0]  req_tag3_i,
    output logic [3:0]        grant_o,
    input  logic              cdb_ready_i,
    input  logic              flush_i,
    output logic              cdb_valid_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [1:0]        cdb_src_o
);

    cdb_word_t         cdb_r;
    logic [1:0]        ptr_r;
    logic [3:0]        pick_gnt_s;
    logic [1:0]        sel_s;
    logic              can_load_s;
    logic              grant_en_s;
    logic [3:0]        grant_s;
    logic              grant_any_s;
    logic [DATA_W-1:0] data_mux_s;
    logic [TAG_W-1:0]  tag_mux_s;

    // The output register may take a new word when empty or draining this cycle.
    assign can_load_s  = !cdb_r.valid || cdb_ready_i;
    assign grant_en_s  = !flush_i && can_load_s;
    assign grant_s     = grant_en_s ? pick_gnt_s : 4'b0000;
    assign grant_any_s = |grant_s;

    // Reset gating lives only on the port so rst_n never feeds a flop's data path.
    assign grant_o = rst_n ? grant_s : 4'b0000;

    rr_pick4 u_pick (
        .req (req_valid_i),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (sel_s)
    );

    mux4_1 #(.WIDTH(DATA_W)) u_data_mux (
        .d0  (req_data0_i),
        .d1  (req_data1_i),
        .d2  (req_data2_i),
        .d3  (req_data3_i),
        .sel (sel_s),
        .y   (data_mux_s)
    );

    mux4_1 #(.WIDTH(TAG_W)) u_tag_mux (
        .d0  (req_tag0_i),
        .d1  (req_tag1_i),
        .d2  (req_tag2_i),
        .d3  (req_tag3_i),
        .sel (sel_s),
        .y   (tag_mux_s)
    );

    // CDB word and priority pointer; flush wins, then grant, then drain, else stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_r <= '0;
            ptr_r <= 2'd0;
        end else if (flush_i) begin
            cdb_r.valid <= 1'b0;
        end else if (grant_any_s) begin
            cdb_r.valid <= 1'b1;
            cdb_r.data  <= data_mux_s;
            cdb_r.tag   <= tag_mux_s;
            cdb_r.src   <= sel_s;
            ptr_r       <= sel_s + 2'd1;
        end else if (can_load_s) begin
            cdb_r.valid <= 1'b0;
        end else begin
            cdb_r <= cdb_r;
            ptr_r <= ptr_r;
        end
    end

    assign cdb_valid_o = cdb_r.valid;
    assign cdb_data_o  = cdb_r.data;
    assign cdb_tag_o   = cdb_r.tag;
    assign cdb_src_o   = cdb_r.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration model.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data0_i, req_data1_i, req_data2_i, req_data3_i;
    logic [5:0]  req_tag0_i, req_tag1_i, req_tag2_i, req_tag3_i;
    logic [3:0]  grant_o;
    logic        cdb_ready_i;
    logic        flush_i;
    logic        cdb_valid_o;
    logic [31:0] cdb_data_o;
    logic [5:0]  cdb_tag_o;
    logic [1:0]  cdb_src_o;

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data0_i (req_data0_i),
        .req_data1_i (req_data1_i),
        .req_data2_i (req_data2_i),
        .req_data3_i (req_data3_i),
        .req_tag0_i  (req_tag0_i),
        .req_tag1_i  (req_tag1_i),
        .req_tag2_i  (req_tag2_i),
        .req_tag3_i  (req_tag3_i),
        .grant_o     (grant_o),
        .cdb_ready_i (cdb_ready_i),
        .flush_i     (flush_i),
        .cdb_valid_o (cdb_valid_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_src_o   (cdb_src_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  t;
        logic [1:0]  s;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    // Requester state: pending valid, data and tag per unit.
    logic [3:0]  pv;
    logic [31:0] pd[4];
    logic [5:0]  pt[4];

    // Reference model: priority start index and whether the bus holds a word.
    int          m_ptr;
    bit          m_valid;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One bus cycle: apply inputs, predict the grant, check, then advance the model.
    task automatic drive(input bit rdy, input bit fl, input bit refill);
        bit         can_load;
        int         w;
        int         idx;
        logic [3:0] eg;
        req_valid_i = pv;
        req_data0_i = pd[0]; req_data1_i = pd[1]; req_data2_i = pd[2]; req_data3_i = pd[3];
        req_tag0_i  = pt[0]; req_tag1_i  = pt[1]; req_tag2_i  = pt[2]; req_tag3_i  = pt[3];
        cdb_ready_i = rdy;
        flush_i     = fl;
        @(negedge clk);
        can_load = !m_valid || rdy;
        w  = -1;
        eg = 4'b0000;
        if (!fl && can_load) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (w < 0 && pv[idx]) w = idx;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        chk("grant", {60'd0, grant_o}, {60'd0, eg});
        chk("cdb_valid", {63'd0, cdb_valid_o}, {63'd0, m_valid});
        if (fl) begin
            m_valid = 1'b0;
        end else if (w >= 0) begin
            q.push_back('{d: pd[w], t: pt[w], s: 2'(w)});
            m_valid = 1'b1;
            m_ptr   = (w + 1) % 4;
            if (!refill) pv[w] = 1'b0;
        end else if (can_load) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves the bus when accepted (compared) or flushed (discarded).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cdb_valid_o && (flush_i || cdb_ready_i)) begin
            if (q.size() == 0) begin
                chk("cdb_unexpected", {63'd0, cdb_valid_o}, 64'd0);
            end else begin
                e = q.pop_front();
                if (!flush_i) begin
                    chk("cdb_data", {32'd0, cdb_data_o}, {32'd0, e.d});
                    chk("cdb_tag", {58'd0, cdb_tag_o}, {58'd0, e.t});
                    chk("cdb_src", {62'd0, cdb_src_o}, {62'd0, e.s});
                end
            end
        end
    end

    task automatic check_cleared(input string nm);
        chk({nm, "_valid"}, {63'd0, cdb_valid_o}, 64'd0);
        chk({nm, "_data"}, {32'd0, cdb_data_o}, 64'd0);
        chk({nm, "_tag"}, {58'd0, cdb_tag_o}, 64'd0);
        chk({nm, "_src"}, {62'd0, cdb_src_o}, 64'd0);
        chk({nm, "_grant"}, {60'd0, grant_o}, 64'd0);
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        check_cleared("async_rst");
        q.delete();
        m_ptr   = 0;
        m_valid = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        pv          = 4'b0000;
        for (int i = 0; i < 4; i++) begin pd[i] = 32'd0; pt[i] = 6'd0; end
        req_valid_i = 4'($urandom_range(1, 15));
        req_data0_i = $urandom; req_data1_i = $urandom; req_data2_i = $urandom; req_data3_i = $urandom;
        req_tag0_i  = 6'd1; req_tag1_i = 6'd2; req_tag2_i = 6'd3; req_tag3_i = 6'd4;
        cdb_ready_i = 1'b1;
        flush_i     = 1'b0;
        m_ptr       = 0;
        m_valid     = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle after reset.
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        check_cleared("idle");

        // Single requester granted every cycle.
        pv = 4'b0100; pd[2] = 32'hDEAD_BEEF; pt[2] = 6'd17;
        repeat (4) begin
            drive(1'b1, 1'b0, 1'b1);
            chk("single_src", {62'd0, cdb_src_o}, 64'd2);
            chk("single_data", {32'd0, cdb_data_o}, 64'hDEAD_BEEF);
        end
        pv = 4'b0000;
        drive(1'b1, 1'b0, 1'b0);

        // Round-robin from reset, then async reset mid-stream.
        async_reset_pulse();
        pv = 4'b1111;
        for (int i = 0; i < 4; i++) begin pd[i] = 32'hA000_0000 + 32'(i); pt[i] = 6'(10 + i); end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            chk("rr_src", {62'd0, cdb_src_o}, 64'(k % 4));
        end
        async_reset_pulse();
        drive(1'b1, 1'b0, 1'b1);
        chk("post_rst_src", {62'd0, cdb_src_o}, 64'd0);
        pv = 4'b0000;
        drive(1'b1, 1'b0, 1'b0);

        // Backpressure: ALU word held while a MUL request waits.
        pv = 4'b0001; pd[0] = 32'h1234_5678; pt[0] = 6'd5;
        drive(1'b1, 1'b0, 1'b0);
        pv = 4'b0010; pd[1] = 32'hCAFE_F00D; pt[1] = 6'd9;
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("stall_tag", {58'd0, cdb_tag_o}, 64'd5);
            chk("stall_valid", {63'd0, cdb_valid_o}, 64'd1);
        end
        drive(1'b1, 1'b0, 1'b0);
        chk("bp_src", {62'd0, cdb_src_o}, 64'd1);
        chk("bp_tag", {58'd0, cdb_tag_o}, 64'd9);
        drive(1'b1, 1'b0, 1'b0);

        // Flush with a valid word and pending ALU/LSU requests.
        pv = 4'b1001; pd[0] = 32'h0000_00AA; pt[0] = 6'd20; pd[3] = 32'h0000_00BB; pt[3] = 6'd23;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("flush_valid", {63'd0, cdb_valid_o}, 64'd0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        pv = 4'b0000;
        drive(1'b1, 1'b0, 1'b0);

        // Randomized traffic honouring the requester contract.
        repeat (500) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pd[i] = $urandom;
                    pt[i] = 6'($urandom_range(0, 63));
                end
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 1'b0);
        end
        for (int n = 0; n < 20 && pv != 4'b0000; n++) drive(1'b1, 1'b0, 1'b0);
        chk("drain_pending", {60'd0, pv}, 64'd0);
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
